// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizes the pin clock/data, frames 11-bit words.
// Optional odd-parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_rx #(
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       clk_ps2_raw,
    input  logic       ps2_data,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       parity_err_out,
    output logic       frame_err_out
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

    state_e        state_q, state_d;
    logic          clk_s1_q, clk_s2_q, clk_dly_q;
    logic          dat_s1_q, dat_s2_q;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;
    logic          fall;
    logic          timeout_hit;
    logic          parity_ok;

`ifdef PS2_PARITY_CHECK_EN
    logic parity_q, parity_d;
    assign parity_ok = ^{shift_q, parity_q};
`else
    assign parity_ok = 1'b1;
`endif

    assign fall        = clk_dly_q & ~clk_s2_q;
    // The edge wins over a simultaneous timeout.
    assign timeout_hit = (state_q != IDLE) && !fall && (tmo_q == TMO_LAST);

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (fall && !dat_s2_q) state_d = DATA;
            DATA:    if (fall && bit_cnt_q == 3'd7) state_d = PARITY;
            PARITY:  if (fall) state_d = STOP;
            STOP:    if (fall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (timeout_hit) state_d = IDLE;
    end

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        parity_d  = parity_q;
`endif
        tmo_d     = (state_d == IDLE || fall) ? '0 : tmo_q + 1'b1;

        unique case (state_q)
            IDLE: if (fall && !dat_s2_q) bit_cnt_d = '0;
            DATA: if (fall) begin
                shift_d   = {dat_s2_q, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                if (fall) parity_d = dat_s2_q;
`endif
            end
            STOP: if (fall) begin
                if (!dat_s2_q) begin
                    ferr_d = 1'b1;
                end else if (parity_ok) begin
                    valid_d = 1'b1;
                    data_d  = shift_q;
                end else begin
                    perr_d = 1'b1;
                end
            end
            default: ;
        endcase
        if (timeout_hit) ferr_d = 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            clk_dly_q <= 1'b1;
            dat_s1_q  <= 1'b1;
            dat_s2_q  <= 1'b1;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tmo_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            clk_s1_q  <= clk_ps2_raw;
            clk_s2_q  <= clk_s1_q;
            clk_dly_q <= clk_s2_q;
            dat_s1_q  <= ps2_data;
            dat_s2_q  <= dat_s1_q;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tmo_q     <= tmo_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
`ifdef PS2_PARITY_CHECK_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign data_out       = data_q;
    assign valid_out      = valid_q;
    assign parity_err_out = perr_q;
    assign frame_err_out  = ferr_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: frame table plus timeout and mid-frame reset sequences.
module tb_ps2_rx;

    localparam int unsigned TMO = 300;
    localparam logic [1:0] K_VALID = 2'd0, K_PERR = 2'd1, K_FERR = 2'd2;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b0;
    logic       clk_ps2_raw = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] data_out;
    logic       valid_out, parity_err_out, frame_err_out;

    ps2_rx #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .clk_ps2_raw   (clk_ps2_raw),
        .ps2_data      (ps2_data),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .parity_err_out(parity_err_out),
        .frame_err_out (frame_err_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [1:0] kind;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic [1:0] kind;
        logic [7:0] exp_data;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_fall_cyc = 0;
    int   tmo_expect_cyc = -1;
    logic [7:0] hold_exp = 8'h00;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk_in) begin
        if (valid_out || parity_err_out || frame_err_out) begin
            logic [1:0] k;
            exp_t e;
            chk("pulse_exclusive", $countones({valid_out, parity_err_out, frame_err_out}), 1);
            k = valid_out ? K_VALID : (parity_err_out ? K_PERR : K_FERR);
            if (sb.size() == 0) begin
                chk("unexpected_pulse_kind", {30'd0, k}, 32'd3);
            end else begin
                e = sb.pop_front();
                chk("pulse_kind", {30'd0, k}, {30'd0, e.kind});
                if (e.kind == K_VALID) chk("pulse_data", {24'd0, data_out}, {24'd0, e.data});
                if (tmo_expect_cyc >= 0 && k == K_FERR) begin
                    chk("timeout_cycle", cyc, tmo_expect_cyc);
                    tmo_expect_cyc = -1;
                end
            end
        end
    end

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            #250 ps2_data = f[i];
            #250 clk_ps2_raw = 1'b0;
            last_fall_cyc = cyc;
            #500 clk_ps2_raw = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    function automatic logic [10:0] frame(input logic [7:0] d, input logic p, input logic s);
        return {s, p, d, 1'b0};
    endfunction

    task automatic push(input logic [1:0] k, input logic [7:0] d);
        exp_t e;
        e.kind = k;
        e.data = d;
        sb.push_back(e);
        if (k == K_VALID) hold_exp = d;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        chk(name, sb.size(), 0);
        sb.delete();
        chk({name, "_hold"}, {24'd0, data_out}, {24'd0, hold_exp});
    endtask

    initial begin
        vecs[0] = '{8'h00, 1'b1, 1'b1, K_VALID, 8'h00};
        vecs[1] = '{8'hAA, 1'b1, 1'b1, K_VALID, 8'hAA};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, K_VALID, 8'hFF};
`ifdef PS2_PARITY_CHECK_EN
        vecs[3] = '{8'h08, 1'b1, 1'b1, K_PERR,  8'h00};
`else
        vecs[3] = '{8'h08, 1'b1, 1'b1, K_VALID, 8'h08};
`endif
        vecs[4] = '{8'h55, 1'b1, 1'b0, K_FERR,  8'h00};
        vecs[5] = '{8'h12, 1'b1, 1'b1, K_VALID, 8'h12};

        repeat (5) @(posedge clk_in);
        @(negedge clk_in);
        chk("reset_data", {24'd0, data_out}, 32'd0);
        chk("reset_valid", {31'd0, valid_out}, 32'd0);
        chk("reset_perr", {31'd0, parity_err_out}, 32'd0);
        chk("reset_ferr", {31'd0, frame_err_out}, 32'd0);
        rst_in = 1'b1;
        #2000;

        for (int i = 0; i < 6; i++) begin
            push(vecs[i].kind, vecs[i].exp_data);
            send_bits(frame(vecs[i].data, vecs[i].par, vecs[i].stop), 11);
            drain($sformatf("vec%0d", i), 20);
        end

        // Timeout after start + 4 data bits, then the line stays idle.
        push(K_FERR, 8'h00);
        send_bits(frame(8'h3C, 1'b1, 1'b1), 5);
        tmo_expect_cyc = last_fall_cyc + 3 + TMO;
        drain("timeout", TMO + 100);
        chk("timeout_seen", tmo_expect_cyc, -1);
        tmo_expect_cyc = -1;
        push(K_VALID, 8'h3C);
        send_bits(frame(8'h3C, 1'b1, 1'b1), 11);
        drain("after_timeout", 20);

        // Reset mid-frame after start + 3 data bits.
        send_bits(frame(8'h81, 1'b1, 1'b1), 4);
        @(negedge clk_in);
        rst_in = 1'b0;
        repeat (10) @(negedge clk_in);
        chk("midrst_data", {24'd0, data_out}, 32'd0);
        chk("midrst_valid", {31'd0, valid_out}, 32'd0);
        chk("midrst_perr", {31'd0, parity_err_out}, 32'd0);
        chk("midrst_ferr", {31'd0, frame_err_out}, 32'd0);
        rst_in = 1'b1;
        hold_exp = 8'h00;
        #3000;
        chk("midrst_quiet_hold", {24'd0, data_out}, 32'd0);
        push(K_VALID, 8'h81);
        send_bits(frame(8'h81, 1'b1, 1'b1), 11);
        drain("after_reset", 20);

        #1000;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

endmodule
